// File: rtl/series_pkg.sv
// Shared definitions for the series-engine schedulers (ln now, exp/sin later).
package series_pkg;

  // Scheduler FSM encodings, 3-bit.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_START   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_RESP    = 3'd5
  } sched_state_t;

  localparam int DEF_W   = 16;   // engine fixed-point width
  localparam int DEF_TMO = 255;  // watchdog limit in cycles
  localparam int WDOG_W  = 8;    // watchdog counter width

  // Engine handshake levels: eng_done high means idle/done, eng_start high
  // requests a job.
  localparam logic ENG_IDLE = 1'b1;
  localparam logic ENG_GO   = 1'b1;

endpackage

// File: rtl/ln_sched_if.sv
// Requester and engine signal bundle for the ln scheduler.
interface ln_sched_if
  import series_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEF_W
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              eng_start;
  logic [W-1:0]      eng_x;
  logic              eng_done;
  logic [W-1:0]      eng_result;
  logic              busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_x, eng_done, eng_result,
    output req_ack, rsp_valid, rsp_data, rsp_err, eng_start, eng_x, busy
  );

  // Clients plus engine side.
  modport master (
    output req_valid, req_x, eng_done, eng_result,
    input  req_ack, rsp_valid, rsp_data, rsp_err, eng_start, eng_x, busy
  );
endinterface

// File: rtl/ln_sched_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr.
module rr_pick
  import series_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW:0]   pos;
  logic [IW-1:0] cand;

  // Scan from the farthest slot back to ptr so the nearest hit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    pos  = '0;
    cand = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      cand = pos[IW-1:0];
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
    gnt = any ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/ln_sched.sv
// Round-robin scheduler sharing one ln engine between NREQ requesters,
// with a watchdog that aborts jobs whose engine never reports done.
module ln_sched
  import series_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEF_W,
  parameter int TMO  = DEF_TMO
) (
  input logic      clk,
  input logic      rst,
  ln_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  sched_state_t          state, nxt;
  logic [IW-1:0]         ptr, owner, pick_idx;
  logic [NREQ-1:0]       pick_gnt;
  logic                  pick_any;
  logic [WDOG_W-1:0]     wdog;
  logic [W-1:0]          eng_x_q, rsp_data_q;
  logic                  rsp_err_q;
  logic [NREQ:0][W-1:0]  x_acc;
  logic [W-1:0]          pick_x;
  logic                  tmo_hit, eng_idle;

  assign tmo_hit  = (wdog == WDOG_W'(TMO));
  assign eng_idle = (bus.eng_done == ENG_IDLE);

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // One-hot AND-OR mux of the granted operand.
  assign x_acc[0] = '0;
  for (genvar g = 0; g < NREQ; g++) begin : g_xmux
    assign x_acc[g+1] = x_acc[g] | (bus.req_x[g*W +: W] & {W{pick_gnt[g]}});
  end
  assign pick_x = x_acc[NREQ];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // Next-state: never start a busy engine; in RELEASE a timeout wins, in RUN
  // a real completion wins over a simultaneous timeout.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (eng_idle && pick_any) nxt = ST_GRANT;
      ST_GRANT:   nxt = ST_START;
      ST_START:   nxt = ST_RELEASE;
      ST_RELEASE: if (tmo_hit) nxt = ST_RESP;
                  else if (!eng_idle) nxt = ST_RUN;
      ST_RUN:     if (eng_idle || tmo_hit) nxt = ST_RESP;
      ST_RESP:    nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.req_ack   = '0;
    bus.rsp_valid = '0;
    bus.eng_start = 1'b0;
    bus.busy      = (state != ST_IDLE);
    case (state)
      ST_GRANT: bus.req_ack   = NREQ'(1) << owner;
      ST_START: bus.eng_start = ENG_GO;
      ST_RESP:  bus.rsp_valid = NREQ'(1) << owner;
      default: ;
    endcase
  end

  assign bus.eng_x    = eng_x_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

  // Owner/operand capture, watchdog, result capture and pointer rotation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      owner      <= '0;
      eng_x_q    <= '0;
      wdog       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (nxt == ST_GRANT) begin
          owner   <= pick_idx;
          eng_x_q <= pick_x;
        end
        ST_START: wdog <= '0;
        ST_RELEASE: begin
          wdog <= wdog + WDOG_W'(1);
          if (tmo_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          wdog <= wdog + WDOG_W'(1);
          if (eng_idle) begin
            rsp_data_q <= bus.eng_result;
            rsp_err_q  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        ST_RESP: ptr <= (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ln_sched.sv
// Randomized bench for ln_sched with an engine model, client drivers and a
// cycle-level reference model of the scheduling rules.
module tb_ln_sched;
  import series_pkg::*;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = DEF_TMO;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ln_sched_if #(.NREQ(NREQ), .W(W)) bif();
  ln_sched #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

  int nvec = 0;
  int nerr = 0;

  function automatic logic [W-1:0] eng_fn(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = x * W'(3) + W'(1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] get_x(input logic [NREQ*W-1:0] v, input int i);
    return W'(v >> (i*W));
  endfunction

  task automatic set_x(input int i, input logic [W-1:0] v);
    logic [NREQ*W-1:0] m;
    m = (NREQ*W)'({W{1'b1}}) << (i*W);
    bif.req_x = (bif.req_x & ~m) | ((NREQ*W)'(v) << (i*W));
  endtask

  task automatic set_v(input int i, input logic b);
    if (b) bif.req_valid = bif.req_valid | (NREQ'(1) << i);
    else   bif.req_valid = bif.req_valid & ~(NREQ'(1) << i);
  endtask

  // ---------------- engine model and client state ----------------
  bit e_idle = 1, e_run = 0, e_arm = 0, hang = 0, hold = 0, rand_mode = 0;
  int ecnt, pend, lat_min = 1, lat_max = 8, cyc = 0, s_cyc;
  logic [W-1:0] ex;
  logic [NREQ-1:0] reissue = '0;
  int ack_log[$];
  logic [NREQ-1:0] s_ack, s_rsp;
  logic s_start, s_err;
  logic [W-1:0] s_x, s_data;

  // One clock: sample the cycle's outputs, then react after the edge.
  task automatic tick();
    @(negedge clk);
    s_ack = bif.req_ack; s_rsp = bif.rsp_valid; s_start = bif.eng_start;
    s_x = bif.eng_x; s_err = bif.rsp_err; s_data = bif.rsp_data; s_cyc = cyc;
    @(posedge clk); #1; cyc++;
    if (e_run) begin
      if (!hang) begin
        if (ecnt <= 1) begin e_run = 0; e_idle = 1; bif.eng_result = eng_fn(ex); end
        else ecnt--;
      end
    end else if (e_arm) begin
      if (pend <= 1) begin e_arm = 0; e_idle = 0; e_run = 1; end
      else pend--;
    end else if (s_start && e_idle) begin
      ex = s_x;
      bif.eng_result = W'($urandom);
      ecnt = int'($urandom_range(lat_max, lat_min));
      pend = int'($urandom_range(2, 0));
      if (pend == 0) begin e_idle = 0; e_run = 1; end
      else e_arm = 1;
    end
    bif.eng_done = e_idle && !hold;
    for (int i = 0; i < NREQ; i++) begin
      if (s_ack[i]) begin
        ack_log.push_back(i);
        if (reissue[i]) reissue[i] = 1'b0;
        else set_v(i, 1'b0);
        set_x(i, W'($urandom));
      end else if (rand_mode) begin
        if (!bif.req_valid[i]) begin
          if ($urandom_range(3, 0) == 0) begin set_v(i, 1'b1); set_x(i, W'($urandom)); end
        end else if ($urandom_range(63, 0) == 0) set_v(i, 1'b0);
      end
    end
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    while ((bif.busy || !bif.eng_done) && n < 2000) begin tick(); n++; end
    chk(nm, 32'({bif.busy, bif.eng_done}), 32'b01);
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit m_job = 0, m_left = 0, m_err = 0;
  int m_tack, m_trsp, m_own, m_ptr = 0, mc = 0, pk;
  logic [W-1:0] m_x = '0, m_data = '0;
  logic [NREQ-1:0] e_ack, e_rsp;

  always @(negedge clk) begin
    mc++;
    if (!rst) begin
      chk("rst_ack",   32'(bif.req_ack), 0);
      chk("rst_rsp",   32'(bif.rsp_valid), 0);
      chk("rst_start", 32'(bif.eng_start), 0);
      chk("rst_busy",  32'(bif.busy), 0);
      chk("rst_eng_x", 32'(bif.eng_x), 0);
      chk("rst_data",  32'(bif.rsp_data), 0);
      chk("rst_err",   32'(bif.rsp_err), 0);
      m_job = 0; m_ptr = 0; m_x = '0;
    end else begin
      e_ack = (m_job && mc == m_tack) ? NREQ'(1) << m_own : '0;
      e_rsp = (m_job && mc == m_trsp) ? NREQ'(1) << m_own : '0;
      chk("req_ack",   32'(bif.req_ack), 32'(e_ack));
      chk("eng_start", 32'(bif.eng_start), 32'(m_job && mc == m_tack + 1));
      chk("rsp_valid", 32'(bif.rsp_valid), 32'(e_rsp));
      chk("busy",      32'(bif.busy), 32'(m_job));
      chk("eng_x",     32'(bif.eng_x), 32'(m_x));
      if (e_rsp != 0) begin
        chk("rsp_data", 32'(bif.rsp_data), 32'(m_data));
        chk("rsp_err",  32'(bif.rsp_err), 32'(m_err));
      end
      if (m_job) begin
        if (mc == m_trsp) begin
          m_job = 0; m_ptr = (m_own + 1) % NREQ;
        end else if (m_trsp < 0 && mc >= m_tack + 2) begin
          if (m_left && bif.eng_done) begin m_trsp = mc + 1; m_err = 0; m_data = eng_fn(m_x); end
          else if (mc - (m_tack + 2) == TMO) begin m_trsp = mc + 1; m_err = 1; m_data = '0; end
          else if (!bif.eng_done) m_left = 1;
        end
      end else if (bif.eng_done && bif.req_valid != '0) begin
        pk = -1;
        for (int k = 0; k < NREQ; k++)
          if (pk < 0 && ((bif.req_valid >> ((m_ptr + k) % NREQ)) & NREQ'(1)) != '0)
            pk = (m_ptr + k) % NREQ;
        m_job = 1; m_own = pk; m_tack = mc + 1; m_trsp = -1; m_left = 0;
        m_x = get_x(bif.req_x, pk);
      end
    end
  end

  // ---------------- directed phases, then random traffic ----------------
  int exp_ord[5] = '{0, 1, 2, 3, 0};
  int n, st, rc;
  bit seen;

  initial begin
    bif.req_valid = '0; bif.req_x = '0; bif.eng_done = 1'b1; bif.eng_result = '0;
    repeat (3) tick();
    chk("reset_busy", 32'(bif.busy), 0);
    rst = 1'b1;

    // Contention from reset; client 0 re-requests once.
    ack_log.delete();
    reissue = 4'b0001;
    for (int i = 0; i < NREQ; i++) set_x(i, W'($urandom));
    bif.req_valid = 4'hF;
    n = 0;
    while (ack_log.size() < 5 && n < 3000) begin tick(); n++; end
    chk("rr_count", 32'(ack_log.size()), 5);
    for (int k = 0; k < 5 && k < ack_log.size(); k++) chk("rr_order", 32'(ack_log[k]), 32'(exp_ord[k]));
    wait_quiet("contention_quiet");

    // Single request, client 2, x=0x0C00.
    set_x(2, 16'h0C00); set_v(2, 1'b1);
    tick();
    chk("single_ack", 32'(bif.req_ack), 32'b0100);
    chk("single_nostart", 32'(bif.eng_start), 0);
    tick();
    chk("single_start", 32'(bif.eng_start), 1);
    chk("single_ack_gone", 32'(bif.req_ack), 0);
    tick();
    chk("single_start_once", 32'(bif.eng_start), 0);
    n = 0;
    while (bif.rsp_valid == '0 && n < 300) begin tick(); n++; end
    chk("single_rsp", 32'(bif.rsp_valid), 32'b0100);
    chk("single_data", 32'(bif.rsp_data), 32'h2401);
    chk("single_err", 32'(bif.rsp_err), 0);
    chk("single_x_stable", 32'(bif.eng_x), 32'h0C00);
    wait_quiet("single_quiet");

    // Busy engine: no ack while eng_done is low.
    hold = 1; bif.eng_done = 1'b0;
    set_x(1, W'($urandom)); set_v(1, 1'b1);
    repeat (10) begin tick(); chk("busy_no_ack", 32'(bif.req_ack), 0); end
    hold = 0; bif.eng_done = e_idle;
    tick();
    chk("busy_ack", 32'(bif.req_ack), 32'b0010);
    wait_quiet("busy_quiet");

    // Watchdog: engine never comes back.
    hang = 1;
    set_x(3, W'($urandom)); set_v(3, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!s_start && n < 50);
    st = s_cyc;
    n = 0;
    do begin tick(); n++; end while (s_rsp == '0 && n < 600);
    rc = s_cyc;
    chk("wdog_delay", 32'(rc - (st + 1)), 32'(TMO + 1));
    chk("wdog_rsp", 32'(s_rsp), 32'b1000);
    chk("wdog_err", 32'(s_err), 1);
    chk("wdog_data", 32'(s_data), 0);
    repeat (5) tick();
    hang = 0;
    wait_quiet("wdog_quiet");

    // Reset mid-job.
    lat_min = 30; lat_max = 40;
    set_x(0, 16'h0BAD); set_v(0, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!s_start && n < 50);
    repeat (5) tick();
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bif.busy), 0);
    chk("mid_rst_eng_x", 32'(bif.eng_x), 0);
    chk("mid_rst_ack", 32'(bif.req_ack), 0);
    repeat (3) tick();
    rst = 1'b1;
    lat_min = 1; lat_max = 8;
    seen = 0; n = 0;
    while ((bif.busy || !bif.eng_done) && n < 2000) begin tick(); n++; if (s_rsp != '0) seen = 1; end
    chk("no_rsp_after_reset", 32'(seen), 0);
    set_x(1, 16'h1234); set_v(1, 1'b1);
    n = 0;
    while (bif.rsp_valid == '0 && n < 300) begin tick(); n++; end
    chk("post_rst_rsp", 32'(bif.rsp_valid), 32'b0010);
    chk("post_rst_data", 32'(bif.rsp_data), 32'h369D);
    chk("post_rst_err", 32'(bif.rsp_err), 0);
    wait_quiet("post_rst_quiet");

    // Random traffic with occasional engine-busy windows.
    lat_max = 12;
    rand_mode = 1;
    repeat (4000) begin
      tick();
      if ($urandom_range(99, 0) == 0) hold = ~hold;
    end
    rand_mode = 0; hold = 0;
    bif.req_valid = '0;
    wait_quiet("final_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ln_sched.md
# ln_sched

Round-robin scheduler that shares one ln Maclaurin engine (controller plus datapath) between `NREQ` independent requesters. It sits between client blocks and the engine. It owns the engine's level-sensitive `start` handshake, holds the operand stable while the engine loads it, captures the result, and returns it to the originating requester. A watchdog aborts any job whose engine never reports completion.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `W`, 16: operand/result width (engine fixed-point width).
- `TMO`, 255: watchdog limit in cycles; 8-bit counter.

Ports:
- `clk`  in  1  single clock; all flops rise-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  request per client; held with `req_x` until `req_ack`.
- `req_x`  in  NREQ*W  operand; client i uses bits [i*W +: W].
- `req_ack`  out  NREQ  one-hot, 1-cycle pulse; the client's operand is captured.
- `rsp_valid`  out  NREQ  one-hot, 1-cycle pulse to the owning client.
- `rsp_data`  out  W  result; valid only with `rsp_valid`.
- `rsp_err`  out  1  qualifies `rsp_valid`; 1 means watchdog abort (`rsp_data`=0).
- `eng_start`  out  1  engine start level.
- `eng_x`  out  W  engine operand.
- `eng_done`  in  1  engine idle/done level (high while the engine is idle).
- `eng_result`  in  W  engine ln result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, GRANT, START, RELEASE, RUN, RESP. All outputs are Moore, decoded from registered state and registers.
- IDLE: when `eng_done`=1 and any `req_valid`, pick the first requester at or after `ptr`, wrapping modulo NREQ.
  - Register the pick in `owner`, latch its `req_x` into `eng_x`, and go to GRANT.
  - If `eng_done`=0, stay in IDLE. The engine is never started unless it is idle.
- GRANT: `req_ack[owner]`=1; go to START.
- START: `eng_start`=1; go to RELEASE.
- RELEASE: `eng_start`=0. Go to RUN once `eng_done`=0 (the engine has left its idle state).
- RUN: wait for `eng_done`=1, then capture `eng_result` into `rsp_data` and go to RESP.
- RESP: `rsp_valid[owner]`=1 and `rsp_err` as set. Then `ptr` ← (owner+1) mod NREQ and go to IDLE.
- Watchdog: an 8-bit counter clears on entry to RELEASE and increments in RELEASE and RUN.
  - On reaching TMO: `rsp_err`←1, `rsp_data`←0, go to RESP. The engine is left to finish on its own.
  - IDLE then waits for `eng_done`=1 before the next grant.
- `eng_x` stays constant from GRANT until the next grant. This covers the engine's operand load.
- A requester that drops `req_valid` before its ack is simply not granted. After its ack, a request is committed.
- Requests that arrive during service are held pending by their clients. Each served client moves to lowest priority.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state=IDLE, `ptr`=0, `owner`=0;
  - all outputs 0, including `eng_x`, `rsp_data` and `rsp_err`.
- Reset in mid-job abandons the job. No `rsp_valid` is issued.
- From a request seen in IDLE at cycle 0: `req_ack` at cycle 1 and `eng_start` at cycle 2.
- `rsp_valid` comes 1 cycle after the cycle in which RUN samples `eng_done`=1.
- Overhead beyond the engine's own latency is 4 cycles. Back-to-back jobs need at least 1 IDLE cycle between them.
- Simultaneous requests: exactly one ack per job, in round-robin order.
- `eng_done` glitching high during RELEASE is ignored. Only the transition to RUN arms completion detection.

## Structure
- Shared package/header `series_pkg`:
  - FSM state encodings (3-bit);
  - default `W` and `TMO`;
  - the engine handshake constants reused by the future exp/sin schedulers.
- One sub-module, `rr_pick`: a combinational round-robin selector taking `req_valid` and `ptr`, and returning a one-hot grant and an index.
- The FSM, watchdog, and operand/result registers live in `ln_sched`.

## Test plan
- Single request: client 2 requests with x=0x0C00 against the engine model.
  - Expect `req_ack`=0b0100 at cycle 1 and `eng_start` high for exactly 1 cycle at cycle 2.
  - Expect `rsp_valid`=0b0100 with `rsp_data`=model result and `rsp_err`=0.
- Contention: all 4 clients request at once from reset.
  - Service order must be 0,1,2,3.
  - Client 0 re-requests immediately, so the next order is 0 after 3, with no starvation.
- Busy engine: hold `eng_done`=0 while a request is pending.
  - Expect no `req_ack` until `eng_done` rises, then normal service.
- Watchdog: the engine model never returns `eng_done`.
  - Expect `rsp_valid` exactly TMO+1 cycles after RELEASE entry, with `rsp_err`=1 and `rsp_data`=0.
- Reset mid-job: assert `rst`=0 during RUN.
  - All outputs go 0 immediately and no `rsp_valid` is issued.
  - After release, a new request from client 1 is served normally.
- Operand stability: change `req_x` after the ack.
  - `eng_x` must keep the captured value through completion.
